// File: rtl/serial_adder.sv
// Bit-serial adder: captures a/b/cin on start, adds one bit per cycle LSB first,
// publishes sum/cout on completion. Optional signed overflow output: SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH-1:0]     a_sh_r;
  logic [WIDTH-1:0]     b_sh_r;
  logic [WIDTH-2:0]     sum_sh_r;
  logic [WIDTH-1:0]     sum_ext_s;
  logic [WIDTH-1:0]     sum_r;
  logic                 carry_r;
  logic                 cout_r;
  logic                 busy_r;
  logic                 done_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [1:0]           fa_s;
  logic                 last_bit_s;
`ifdef SERIAL_ADDER_OVF_EN
  logic                 ovf_r;
`endif

  // One-bit full adder, returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  // Bit-slice arithmetic and next-state decode.
  always_comb begin
    fa_s       = full_add(a_sh_r[0], b_sh_r[0], carry_r);
    last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
    sum_ext_s  = {fa_s[0], sum_sh_r};
    state_s    = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {(WIDTH-1){1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cout_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            carry_r  <= cin;
            sum_sh_r <= {(WIDTH-1){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= fa_s[1];
          sum_sh_r <= sum_ext_s[WIDTH-1:1];
          cnt_r    <= cnt_r + CNT_W'(1);
          // Result becomes visible only once all bits are in.
          if (last_bit_s) begin
            sum_r  <= sum_ext_s;
            cout_r <= fa_s[1];
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r  <= carry_r ^ fa_s[1];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed WIDTH=8 vectors plus a full WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       ovf;
    logic       cout;
    logic [7:0] sum;
  } exp8_t;

  exp8_t      q8[$];
  logic [5:0] q4[$];
  logic [7:0] prev_sum8;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done8: got done=1, required no pending result");
      end else begin
        exp8_t e;
        e = q8.pop_front();
        check("sum8", 32'(sum8), 32'(e.sum));
        check("cout8", 32'(cout8), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
      end
    end
  end

  // Scoreboard monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done4: got done=1, required no pending result");
      end else begin
        logic [5:0] e;
        e = q4.pop_front();
        check("sum4_cout4", 32'({cout4, sum4}), 32'(e[4:0]));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf4", 32'(ovf4), 32'(e[5]));
`endif
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo,
                     input bit hold, input bit scramble);
    int  k, total, bcnt;
    bit  stable, excl;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back('{ovf: eo, cout: ec, sum: es});
    k = 0;
    while (k < 40 && busy8 !== 1'b1) begin
      @(posedge clk); #1; k++;
    end
    check("accept_timeout8", 32'(busy8), 32'd1);
    if (!hold) start8 = 1'b0;
    total = k; bcnt = 0; stable = 1'b1; excl = 1'b1;
    while (total < 80 && done8 !== 1'b1) begin
      if (busy8 === 1'b1) bcnt++;
      if (sum8 !== prev_sum8) stable = 1'b0;
      if (scramble && bcnt == 3) begin
        a8 = ~a8; b8 = ~b8; cin8 = ~cin8;
      end
      @(posedge clk); #1; total++;
      if (busy8 === 1'b1 && done8 === 1'b1) excl = 1'b0;
    end
    check("done_timeout8", 32'(done8), 32'd1);
    check("latency8", 32'(total - (k - 1)), 32'd9);
    check("busy_cycles8", 32'(bcnt), 32'd8);
    check("sum_stable_run8", 32'(stable), 32'd1);
    check("busy_done_excl8", 32'(excl), 32'd1);
    start8 = 1'b0;
    prev_sum8 = es;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int         k;
    logic [4:0] t;
    logic       o;
    t = 5'(a) + 5'(b) + 5'(c);
    o = (a[3] == b[3]) && (t[3] != a[3]);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    q4.push_back({o, t});
    k = 0;
    while (k < 20 && busy4 !== 1'b1) begin
      @(posedge clk); #1; k++;
    end
    start4 = 1'b0;
    while (k < 40 && done4 !== 1'b1) begin
      @(posedge clk); #1; k++;
    end
    if (done4 !== 1'b1) check("done_timeout4", 32'(done4), 32'd1);
  endtask

  initial begin
    int  k;
    bit  no_done;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;
    prev_sum8 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf8), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    op8(8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("sum_hold_idle", 32'(sum8), 32'h51);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Start held through RUN with operands scrambled mid-operation.
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("no_reaccept", 32'(busy8), 32'd0);

    // Back-to-back: second start driven during the done cycle.
    op8(8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0, 1'b0, 1'b0);
    op8(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset four cycles into RUN aborts without a done pulse.
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; start8 = 1'b1;
    k = 0;
    while (k < 20 && busy8 !== 1'b1) begin
      @(posedge clk); #1; k++;
    end
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_cout", 32'(cout8), 32'd0);
    no_done = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) no_done = 1'b0;
    end
    check("abort_no_done", 32'(no_done), 32'd1);
    prev_sum8 = 8'h00;
    op8(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Exhaustive 4-bit sweep, chained back-to-back.
    for (int i = 0; i < 512; i++) begin
      op4(4'(i >> 5), 4'(i >> 1), 1'(i));
    end

    k = 0;
    while (k < 20 && (q8.size() != 0 || q4.size() != 0)) begin
      @(posedge clk); #1; k++;
    end
    check("pending8", 32'(q8.size()), 32'd0);
    check("pending4", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
